// File: rtl/vga_pattern_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_scheduler_if
// Description : Mode-request handshake between a controller (master) and the
//               VGA pattern scheduler (slave).
//                 mode_valid  master->slave  request valid
//                 mode        master->slave  requested mode (0..3)
//                 mode_ready  slave->master  scheduler can accept a request
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_pattern_scheduler_if;
   logic       mode_valid;
   logic [1:0] mode;
   logic       mode_ready;

   modport master (output mode_valid, output mode, input mode_ready);
   modport slave  (input mode_valid, input mode, output mode_ready);
endinterface
`default_nettype wire

// File: rtl/vga_pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_scheduler
// Description : Selects the pixel colour for a VGA raster. Four patterns
//               (SOLID, BARS, CHECKER, CYCLE); mode requests are accepted
//               via a valid/ready handshake and applied only at frame
//               boundaries. The user colour is sampled once per frame.
// Ports       : clk_100MHz  system clock
//               reset       asynchronous active-high reset
//               p_tick      pixel enable (1 clk every 4)
//               video_on    visible-area flag
//               x, y        current pixel column / row
//               sw          user colour {R,G,B}
//               req         mode-request handshake (slave side)
//               active_mode mode currently displayed
//               frame_end   1-clk pulse at the frame boundary
//               frame_cnt   frames since reset (mod 256)
//               rgb         registered pixel colour
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_scheduler #(
   parameter int FRAMES_PER_STEP = 60,
   parameter int H_ACTIVE        = 640,
   parameter int V_ACTIVE        = 480
) (
   input  wire                          clk_100MHz,
   input  wire                          reset,
   input  wire                          p_tick,
   input  wire                          video_on,
   input  wire  [9:0]                   x,
   input  wire  [9:0]                   y,
   input  wire  [11:0]                  sw,
   vga_pattern_scheduler_if.slave       req,
   output logic [1:0]                   active_mode,
   output logic                         frame_end,
   output logic [7:0]                   frame_cnt,
   output logic [11:0]                  rgb
);

   localparam logic [1:0] MODE_SOLID   = 2'd0;
   localparam logic [1:0] MODE_BARS    = 2'd1;
   localparam logic [1:0] MODE_CHECKER = 2'd2;
   localparam logic [1:0] MODE_CYCLE   = 2'd3;

   localparam logic [7:0] DIV_LAST  = 8'(FRAMES_PER_STEP - 1);
   // Bar width is one eighth of the visible line (80 px at 640).
   localparam int         BAR_W     = H_ACTIVE / 8;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  pending_q, pending_d;
   logic [1:0]  active_q, active_d;
   logic [11:0] color_q;
   logic [2:0]  step_q;
   logic [7:0]  div_q;
   logic [7:0]  frame_cnt_q;
   logic [11:0] rgb_q;

   logic [2:0]  bar_idx;
   logic [11:0] pattern;
   logic        enter_cycle;

   function automatic logic [11:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_color = 12'hFFF;
         3'd1:    bar_color = 12'hFF0;
         3'd2:    bar_color = 12'h0FF;
         3'd3:    bar_color = 12'h0F0;
         3'd4:    bar_color = 12'hF0F;
         3'd5:    bar_color = 12'hF00;
         3'd6:    bar_color = 12'h00F;
         default: bar_color = 12'h000;
      endcase
   endfunction

   // Gated by reset so the pulse is low while reset is held.
   assign frame_end = ~reset & p_tick & (x == 10'd0) & (y == 10'(V_ACTIVE));

   // Bar index = number of bar boundaries at or left of x.
   assign bar_idx = 3'(x >= 10'(1 * BAR_W)) + 3'(x >= 10'(2 * BAR_W))
                  + 3'(x >= 10'(3 * BAR_W)) + 3'(x >= 10'(4 * BAR_W))
                  + 3'(x >= 10'(5 * BAR_W)) + 3'(x >= 10'(6 * BAR_W))
                  + 3'(x >= 10'(7 * BAR_W));

   always_comb begin
      pattern = color_q;
      case (active_q)
         MODE_SOLID:   pattern = color_q;
         MODE_BARS:    pattern = bar_color(bar_idx);
         MODE_CHECKER: pattern = (x[5] ^ y[5]) ? ~color_q : color_q;
         MODE_CYCLE:   pattern = bar_color(step_q);
         default:      pattern = color_q;
      endcase
   end

   // ---------------- request FSM ----------------
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pending_q <= MODE_SOLID;
         active_q  <= MODE_SOLID;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         active_q  <= active_d;
      end
   end

   // A request captured in IDLE is only looked at from PENDING, so one
   // accepted on a frame_end cycle waits for the following frame_end.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      active_d  = active_q;
      case (state_q)
         ST_IDLE: begin
            if (req.mode_valid) begin
               pending_d = req.mode;
               state_d   = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (frame_end) begin
               active_d = pending_q;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign enter_cycle = (state_q == ST_PENDING) && frame_end &&
                        (pending_q == MODE_CYCLE) && (active_q != MODE_CYCLE);

   // ---------------- datapath ----------------
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         color_q     <= 12'h000;
         step_q      <= 3'd0;
         div_q       <= 8'd0;
         frame_cnt_q <= 8'd0;
         rgb_q       <= 12'h000;
      end else begin
         if (frame_end) begin
            color_q     <= sw;
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end

         if (enter_cycle || (active_q != MODE_CYCLE)) begin
            step_q <= 3'd0;
            div_q  <= 8'd0;
         end else if (frame_end) begin
            if (div_q == DIV_LAST) begin
               div_q  <= 8'd0;
               step_q <= step_q + 3'd1;
            end else begin
               div_q  <= div_q + 8'd1;
            end
         end

         if (p_tick) begin
            rgb_q <= video_on ? pattern : 12'h000;
         end
      end
   end

   assign req.mode_ready = (state_q == ST_IDLE);
   assign active_mode    = active_q;
   assign frame_cnt      = frame_cnt_q;
   assign rgb            = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_scheduler
// Description : Directed self-checking bench for vga_pattern_scheduler.
//               Pixels and frame boundaries are driven directly rather than
//               by a full raster to keep runtime short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_scheduler;

   localparam int V_ACT = 480;

   logic        clk_100MHz = 1'b0;
   logic        reset      = 1'b1;
   logic        p_tick     = 1'b0;
   logic        video_on   = 1'b0;
   logic [9:0]  x          = 10'd0;
   logic [9:0]  y          = 10'd0;
   logic [11:0] sw         = 12'h000;
   logic [1:0]  active_mode;
   logic        frame_end;
   logic [7:0]  frame_cnt;
   logic [11:0] rgb;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_fc = 8'd0;
   logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};

   vga_pattern_scheduler_if req_if ();

   vga_pattern_scheduler #(
      .FRAMES_PER_STEP (2),
      .H_ACTIVE        (640),
      .V_ACTIVE        (V_ACT)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .reset       (reset),
      .p_tick      (p_tick),
      .video_on    (video_on),
      .x           (x),
      .y           (y),
      .sw          (sw),
      .req         (req_if.slave),
      .active_mode (active_mode),
      .frame_end   (frame_end),
      .frame_cnt   (frame_cnt),
      .rgb         (rgb)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   // Stimulus helpers: called at a negedge, return at a negedge after the
   // loading posedge, so outputs are sampled mid-cycle.
   task automatic do_pixel(input logic [9:0] px, input logic [9:0] py, input logic von);
      x = px; y = py; video_on = von; p_tick = 1'b1;
      @(negedge clk_100MHz);
      p_tick = 1'b0;
      repeat (3) @(negedge clk_100MHz);
   endtask

   task automatic do_frame_end();
      x = 10'd0; y = 10'(V_ACT); video_on = 1'b0; p_tick = 1'b1;
      @(negedge clk_100MHz);
      p_tick = 1'b0;
      exp_fc = exp_fc + 8'd1;
      repeat (3) @(negedge clk_100MHz);
   endtask

   task automatic test_reset();
      // Drive the frame-boundary condition during reset: pulse must stay low.
      x = 10'd0; y = 10'(V_ACT); p_tick = 1'b1;
      req_if.mode_valid = 1'b0; req_if.mode = 2'd0;
      repeat (3) @(negedge clk_100MHz);
      checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=%h", rgb, 12'h000); end
      checks++; if (active_mode !== 2'd0) begin errors++; $display("FAIL reset_mode got=%0d exp=0", active_mode); end
      checks++; if (req_if.mode_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_if.mode_ready); end
      checks++; if (frame_end !== 1'b0) begin errors++; $display("FAIL reset_frame_end got=%b exp=0", frame_end); end
      checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
      p_tick = 1'b0; y = 10'd0;
      reset = 1'b0;
      repeat (2) @(negedge clk_100MHz);
   endtask

   task automatic test_solid();
      sw = 12'hA5C;
      // frame_end is a single-cycle combinational pulse on the boundary pixel.
      x = 10'd1; y = 10'(V_ACT); p_tick = 1'b1; #1;
      checks++; if (frame_end !== 1'b0) begin errors++; $display("FAIL fe_wrong_x got=%b exp=0", frame_end); end
      x = 10'd0; #1;
      checks++; if (frame_end !== 1'b1) begin errors++; $display("FAIL fe_pulse got=%b exp=1", frame_end); end
      @(negedge clk_100MHz);
      p_tick = 1'b0; exp_fc = exp_fc + 8'd1; #1;
      checks++; if (frame_end !== 1'b0) begin errors++; $display("FAIL fe_width got=%b exp=0", frame_end); end
      repeat (2) @(negedge clk_100MHz);
      checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL solid_frame_cnt got=%0d exp=1", frame_cnt); end
      do_pixel(10'd10, 10'd10, 1'b1);
      checks++; if (rgb !== 12'hA5C) begin errors++; $display("FAIL solid_visible got=%h exp=a5c", rgb); end
      // Mid-frame sw change must not show until the next frame boundary.
      sw = 12'h123;
      do_pixel(10'd11, 10'd10, 1'b1);
      checks++; if (rgb !== 12'hA5C) begin errors++; $display("FAIL solid_no_tear got=%h exp=a5c", rgb); end
      do_pixel(10'd700, 10'd10, 1'b0);
      checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL solid_blank got=%h exp=000", rgb); end
      sw = 12'hA5C;
   endtask

   task automatic test_mode_request();
      req_if.mode_valid = 1'b1; req_if.mode = 2'd1;
      @(negedge clk_100MHz);
      req_if.mode_valid = 1'b0;
      checks++; if (req_if.mode_ready !== 1'b0) begin errors++; $display("FAIL req_ready_low got=%b exp=0", req_if.mode_ready); end
      checks++; if (active_mode !== 2'd0) begin errors++; $display("FAIL req_not_yet got=%0d exp=0", active_mode); end
      // A second request while pending is ignored.
      req_if.mode_valid = 1'b1; req_if.mode = 2'd2;
      @(negedge clk_100MHz);
      req_if.mode_valid = 1'b0;
      do_pixel(10'd100, 10'd20, 1'b1);
      checks++; if (rgb !== 12'hA5C) begin errors++; $display("FAIL req_mid_frame got=%h exp=a5c", rgb); end
      do_frame_end();
      checks++; if (active_mode !== 2'd1) begin errors++; $display("FAIL req_applied got=%0d exp=1", active_mode); end
      checks++; if (req_if.mode_ready !== 1'b1) begin errors++; $display("FAIL req_ready_back got=%b exp=1", req_if.mode_ready); end
      checks++; if (frame_cnt !== exp_fc) begin errors++; $display("FAIL req_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_bars();
      logic [9:0]  xs [4] = '{10'd79, 10'd80, 10'd639, 10'd320};
      logic [11:0] es [4] = '{12'hFFF, 12'hFF0, 12'h000, 12'hF0F};
      for (int i = 0; i < 4; i++) begin
         do_pixel(xs[i], 10'd5, 1'b1);
         checks++; if (rgb !== es[i]) begin errors++; $display("FAIL bars_x%0d got=%h exp=%h", xs[i], rgb, es[i]); end
      end
   endtask

   task automatic test_checker();
      sw = 12'h123;
      req_if.mode_valid = 1'b1; req_if.mode = 2'd2;
      @(negedge clk_100MHz);
      req_if.mode_valid = 1'b0;
      do_frame_end();
      checks++; if (active_mode !== 2'd2) begin errors++; $display("FAIL chk_mode got=%0d exp=2", active_mode); end
      do_pixel(10'd0, 10'd0, 1'b1);
      checks++; if (rgb !== 12'h123) begin errors++; $display("FAIL chk_0_0 got=%h exp=123", rgb); end
      do_pixel(10'd32, 10'd0, 1'b1);
      checks++; if (rgb !== 12'hEDC) begin errors++; $display("FAIL chk_32_0 got=%h exp=edc", rgb); end
      do_pixel(10'd32, 10'd32, 1'b1);
      checks++; if (rgb !== 12'h123) begin errors++; $display("FAIL chk_32_32 got=%h exp=123", rgb); end
   endtask

   task automatic test_cycle();
      // Request on the frame_end cycle itself: must wait one more frame.
      req_if.mode_valid = 1'b1; req_if.mode = 2'd3;
      x = 10'd0; y = 10'(V_ACT); video_on = 1'b0; p_tick = 1'b1;
      @(negedge clk_100MHz);
      req_if.mode_valid = 1'b0; p_tick = 1'b0; exp_fc = exp_fc + 8'd1;
      checks++; if (active_mode !== 2'd2) begin errors++; $display("FAIL cyc_deferred got=%0d exp=2", active_mode); end
      checks++; if (req_if.mode_ready !== 1'b0) begin errors++; $display("FAIL cyc_pending got=%b exp=0", req_if.mode_ready); end
      do_frame_end();
      checks++; if (active_mode !== 2'd3) begin errors++; $display("FAIL cyc_applied got=%0d exp=3", active_mode); end
      do_pixel(10'd50, 10'd50, 1'b1);
      checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL cyc_step0 got=%h exp=fff", rgb); end
      do_frame_end();
      do_pixel(10'd50, 10'd50, 1'b1);
      checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL cyc_half_step got=%h exp=fff", rgb); end
      do_frame_end();
      do_pixel(10'd50, 10'd50, 1'b1);
      checks++; if (rgb !== bars[1]) begin errors++; $display("FAIL cyc_step1 got=%h exp=%h", rgb, bars[1]); end
      for (int s = 2; s <= 8; s++) begin
         do_frame_end();
         do_frame_end();
         do_pixel(10'd50, 10'd50, 1'b1);
         checks++; if (rgb !== bars[s % 8]) begin errors++; $display("FAIL cyc_step%0d got=%h exp=%h", s % 8, rgb, bars[s % 8]); end
      end
      checks++; if (frame_cnt !== exp_fc) begin errors++; $display("FAIL cyc_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_reset_pending();
      req_if.mode_valid = 1'b1; req_if.mode = 2'd1;
      @(negedge clk_100MHz);
      req_if.mode_valid = 1'b0;
      checks++; if (req_if.mode_ready !== 1'b0) begin errors++; $display("FAIL rp_pending got=%b exp=0", req_if.mode_ready); end
      #2 reset = 1'b1;
      #1;
      checks++; if (active_mode !== 2'd0) begin errors++; $display("FAIL rp_async_mode got=%0d exp=0", active_mode); end
      checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL rp_async_rgb got=%h exp=000", rgb); end
      checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rp_async_cnt got=%0d exp=0", frame_cnt); end
      repeat (2) @(negedge clk_100MHz);
      reset = 1'b0; exp_fc = 8'd0;
      @(negedge clk_100MHz);
      do_frame_end();
      checks++; if (active_mode !== 2'd0) begin errors++; $display("FAIL rp_discard got=%0d exp=0", active_mode); end
      checks++; if (req_if.mode_ready !== 1'b1) begin errors++; $display("FAIL rp_ready got=%b exp=1", req_if.mode_ready); end
      do_pixel(10'd5, 10'd5, 1'b1);
      checks++; if (rgb !== 12'h123) begin errors++; $display("FAIL rp_solid got=%h exp=123", rgb); end
   endtask

   task automatic test_frame_wrap();
      while (exp_fc != 8'd255) do_frame_end();
      checks++; if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d exp=255", frame_cnt); end
      do_frame_end();
      checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0 got=%0d exp=0", frame_cnt); end
   endtask

   initial begin
      req_if.mode_valid = 1'b0;
      req_if.mode       = 2'd0;
      test_reset();
      test_solid();
      test_mode_request();
      test_bars();
      test_checker();
      test_cycle();
      test_reset_pending();
      test_frame_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_pattern_scheduler.md
VGA_PATTERN_SCHEDULER -- requirements
Module: vga_pattern_scheduler

Interface
REQ-001 Parameter FRAMES_PER_STEP, default 60: frames per CYCLE-mode palette step, legal range 1..255.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 clk_100MHz  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 p_tick  input  1  pixel enable from VGA controller, 1-cycle pulse every 4 clocks.
REQ-007 video_on  input  1  high while (x,y) is in the visible area.
REQ-008 x  input  10  current pixel column.
REQ-009 y  input  10  current pixel row.
REQ-010 sw  input  12  user color {R[11:8],G[7:4],B[3:0]}.
REQ-011 mode_valid  input  1  mode-change request valid.
REQ-012 mode  input  2  requested mode: 0 SOLID, 1 BARS, 2 CHECKER, 3 CYCLE.
REQ-013 mode_ready  output  1  scheduler can accept a mode request.
REQ-014 active_mode  output  2  mode currently driving the display.
REQ-015 frame_end  output  1  1-cycle pulse at each frame boundary.
REQ-016 frame_cnt  output  8  frames since reset, wraps 255->0.
REQ-017 rgb  output  12  registered pixel color to the DAC pins.

Function
REQ-018 frame_end SHALL pulse for exactly one clk on the cycle where p_tick=1, x=0 and y=V_ACTIVE.
REQ-019 Request FSM SHALL have two states: IDLE (mode_ready=1) and PENDING (mode_ready=0).
REQ-020 In IDLE, mode_valid=1 SHALL capture mode into pending_mode and move to PENDING on the next edge.
REQ-021 In PENDING, mode_valid SHALL be ignored and pending_mode SHALL hold.
REQ-022 In PENDING, on frame_end, active_mode SHALL load pending_mode and the FSM SHALL return to IDLE; mode_ready is 1 on the following cycle.
REQ-023 A request accepted in IDLE on the same cycle as frame_end SHALL NOT apply at that frame_end; it SHALL apply at the next one.
REQ-024 color_reg SHALL load sw only on frame_end, so there is no mid-frame color tearing.
REQ-025 SOLID: pattern = color_reg.
REQ-026 BARS: bar index b = count of thresholds {80,160,240,320,400,480,560} that are <= x; pattern = BAR[b].
REQ-027 BAR[0..7] SHALL be 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000.
REQ-028 CHECKER: pattern = (x[5]^y[5]) ? ~color_reg : color_reg.
REQ-029 CYCLE: pattern = BAR[step], where step is 3 bits.
REQ-030 In CYCLE, a frame divider SHALL count frame_end pulses; on reaching FRAMES_PER_STEP it SHALL clear and step SHALL increment, wrapping 7->0.
REQ-031 When active_mode changes into CYCLE, step and the divider SHALL clear in that same cycle.
REQ-032 Outside CYCLE, step and the divider SHALL hold at 0.
REQ-033 On p_tick=1, rgb SHALL load (video_on ? pattern : 12'h000).
REQ-034 Without p_tick, rgb SHALL hold. rgb therefore lags its pixel's p_tick cycle by 1 clk.
REQ-035 frame_cnt SHALL increment on every frame_end, modulo 256.
REQ-036 Mode switches SHALL take effect only at frame_end, never mid-frame.

Reset
REQ-037 While reset=1, outputs SHALL be: rgb=0, active_mode=0 (SOLID), mode_ready=1, frame_end=0, frame_cnt=0.
REQ-038 While reset=1, internal state SHALL be: FSM IDLE, pending_mode=0, color_reg=0, step=0, divider=0.
REQ-039 Reset asserted in PENDING SHALL discard the pending request; it is not applied after release.
REQ-040 Reset SHALL take effect asynchronously; the first state update after release occurs on a clk edge with reset low.

Verification
REQ-041 After reset release: sw=12'hA5C, one frame elapses -> visible rgb=12'hA5C, blanking rgb=0, frame_cnt=1.
REQ-042 Request mode=1 mid-frame: mode_ready=0 next cycle; active_mode stays 0 until frame_end, then becomes 1.
REQ-043 In BARS: x=79 -> rgb=12'hFFF; x=80 -> rgb=12'hFF0; x=639 -> rgb=12'h000.
REQ-044 Request mode=3 asserted on the frame_end cycle -> active_mode changes one frame later; then step advances every FRAMES_PER_STEP frames (test with FRAMES_PER_STEP=2), wrapping 7->0.
REQ-045 In CHECKER with color_reg=12'h123: (x,y)=(0,0) -> rgb=12'h123; (x,y)=(32,0) -> rgb=12'hEDC.
REQ-046 Assert reset while PENDING -> after release, active_mode=0, mode_ready=1, and the old request never appears.
